// File: rtl/bike_rearlight_ctrl.sv
// ---------------------------------------------------------------------------
// bike_rearlight_ctrl
//   Bicycle rear-light controller. Scans an 8x8 red/green dot matrix one row
//   at a time and shows the active mode number on a single 7-segment digit.
//
// Ports
//   clk       system clock, everything on the rising edge
//   rst       synchronous reset, active-low
//   sw        power switch (1 = on, 0 = all outputs dark)
//   state_in  mode request {hazard, brake, right, left}; 0000 = idle
//   row       matrix row select, active-low, bit i = row i
//   col_r     red column drive, active-high, bit7 = leftmost column
//   col_g     green column drive, active-high, bit7 = leftmost column
//   seg_row   7-seg digit select, active-low, only digit0 is used
//   seg_col   7-seg segments {dp,g,f,e,d,c,b,a}, active-high
//
// Parameters
//   SCAN_DIV   clocks each matrix row stays selected (>=1)
//   BLINK_DIV  clocks per blink half-period (>=2)
//
// Configuration macro
//   BRAKE_STROBE_EN  when defined, BRAKE blinks at twice the normal blink
//                    rate instead of staying steady.
//
// Timing
//   state_in -> mode register (1 clk) -> registered outputs (1 clk).
//   A mode change clears the blink counter and forces the phase on, so a
//   freshly selected blinking mode is lit straight away.
//   With sw=0 the scan and blink counters hold, the phase is parked on, and
//   the mode register keeps tracking state_in.
// ---------------------------------------------------------------------------
module bike_rearlight_ctrl #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw,
  input  logic [3:0] state_in,
  output logic [7:0] row,
  output logic [7:0] col_r,
  output logic [7:0] col_g,
  output logic [7:0] seg_row,
  output logic [7:0] seg_col
);

  localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
`ifdef BRAKE_STROBE_EN
  localparam logic [BLINK_W-1:0] STROBE_LAST = BLINK_W'(BLINK_DIV / 2 - 1);
`endif

  typedef enum logic [2:0] {
    M_IDLE   = 3'd0,
    M_LEFT   = 3'd1,
    M_RIGHT  = 3'd2,
    M_BRAKE  = 3'd3,
    M_HAZARD = 3'd4
  } mode_e;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Requests are not trusted to be one-hot: brake must always win because it
  // is the safety-critical indication, hazard next, then the turn signals.
  function automatic mode_e decode(input logic [3:0] s);
    mode_e m;
    if (s[2])      m = M_BRAKE;
    else if (s[3]) m = M_HAZARD;
    else if (s[0]) m = M_LEFT;
    else if (s[1]) m = M_RIGHT;
    else           m = M_IDLE;
    return m;
  endfunction

  // Bitmap for one row of the current mode (bit7 = leftmost column).
  function automatic logic [7:0] pattern(input mode_e m, input logic [2:0] r);
    logic [7:0] p;
    p = 8'hFF;
    case (m)
      M_IDLE: begin
        // hollow frame
        p = (r == 3'd0 || r == 3'd7) ? 8'hFF : 8'h81;
      end
      M_LEFT: begin
        case (r)
          3'd0, 3'd7: p = 8'h00;
          3'd1, 3'd6: p = 8'h20;
          3'd2, 3'd5: p = 8'h60;
          default:    p = 8'hFF;
        endcase
      end
      M_RIGHT: begin
        case (r)
          3'd0, 3'd7: p = 8'h00;
          3'd1, 3'd6: p = 8'h04;
          3'd2, 3'd5: p = 8'h06;
          default:    p = 8'hFF;
        endcase
      end
      default: p = 8'hFF;  // brake and hazard light the full matrix
    endcase
    return p;
  endfunction

  function automatic logic [7:0] seg_code(input mode_e m);
    logic [7:0] c;
    case (m)
      M_IDLE:   c = 8'h3F;  // '0'
      M_LEFT:   c = 8'h06;  // '1'
      M_RIGHT:  c = 8'h5B;  // '2'
      M_BRAKE:  c = 8'h4F;  // '3'
      M_HAZARD: c = 8'h66;  // '4'
      default:  c = 8'h00;
    endcase
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  mode_e              mode_q;
  logic [2:0]         row_idx;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  // -------------------------------------------------------------------------
  // Next-value logic for the display registers
  // -------------------------------------------------------------------------
  mode_e              mode_d;
  logic [7:0]         pat;
  logic               red_en, grn_en, blinks, lit;
  logic [BLINK_W-1:0] blink_last;

  always_comb begin
    mode_d = decode(state_in);
    pat    = pattern(mode_q, row_idx);

    red_en = 1'b0;
    grn_en = 1'b0;
    blinks = 1'b0;
    case (mode_q)
      M_IDLE:   red_en = 1'b1;
      M_LEFT:   begin grn_en = 1'b1; blinks = 1'b1; end
      M_RIGHT:  begin grn_en = 1'b1; blinks = 1'b1; end
      M_BRAKE: begin
        red_en = 1'b1;
`ifdef BRAKE_STROBE_EN
        blinks = 1'b1;
`endif
      end
      M_HAZARD: begin red_en = 1'b1; grn_en = 1'b1; blinks = 1'b1; end
      default:  red_en = 1'b0;
    endcase

    lit = ~blinks | phase;

`ifdef BRAKE_STROBE_EN
    blink_last = (mode_q == M_BRAKE) ? STROBE_LAST : BLINK_LAST;
`else
    blink_last = BLINK_LAST;
`endif
  end

  // -------------------------------------------------------------------------
  // Mode FSM, scan/blink timing and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= M_IDLE;
      row_idx   <= 3'd0;
      scan_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      row       <= 8'hFF;
      col_r     <= 8'h00;
      col_g     <= 8'h00;
      seg_row   <= 8'hFF;
      seg_col   <= 8'h00;
    end else begin
      mode_q <= mode_d;

      // Outputs are built from the registered mode, so a request reaches
      // the display two edges after it is presented.
      if (sw) begin
        row     <= ~(8'h01 << row_idx);
        col_r   <= (red_en && lit) ? pat : 8'h00;
        col_g   <= (grn_en && lit) ? pat : 8'h00;
        seg_row <= 8'hFE;
        seg_col <= seg_code(mode_q);
      end else begin
        row     <= 8'hFF;
        col_r   <= 8'h00;
        col_g   <= 8'h00;
        seg_row <= 8'hFF;
        seg_col <= 8'h00;
      end

      // Row scan only advances while powered.
      if (sw) begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt <= '0;
          row_idx  <= row_idx + 3'd1;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end

      // Blink: a mode change restarts the on half-period; while switched off
      // the count holds and the phase is parked on so power-up shows lit.
      if (mode_d != mode_q) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (!sw) begin
        phase     <= 1'b1;
      end else if (blink_cnt >= blink_last) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bike_rearlight_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bike_rearlight_ctrl
//   Scoreboard bench. The stimulus process drives one input set per clock
//   and pushes the output word the reference model predicts for the next
//   edge; a separate monitor pops and compares one word per clock.
//   The model tracks elapsed powered clocks as plain integers and derives
//   row index and blink phase from them by division.
// ---------------------------------------------------------------------------
module tb_bike_rearlight_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw  = 1'b0;
  logic [3:0] state_in = 4'h0;
  logic [7:0] row, col_r, col_g, seg_row, seg_col;

  always #5 clk = ~clk;

  bike_rearlight_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .sw(sw), .state_in(state_in),
    .row(row), .col_r(col_r), .col_g(col_g),
    .seg_row(seg_row), .seg_col(seg_col)
  );

  typedef struct packed {
    logic [7:0] row, col_r, col_g, seg_row, seg_col;
  } out_t;

  out_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Mode numbering: 0 idle, 1 left, 2 right, 3 brake, 4 hazard.
  logic [7:0] pat_tab [5][8] = '{
    '{8'hFF,8'h81,8'h81,8'h81,8'h81,8'h81,8'h81,8'hFF},
    '{8'h00,8'h20,8'h60,8'hFF,8'hFF,8'h60,8'h20,8'h00},
    '{8'h00,8'h04,8'h06,8'hFF,8'hFF,8'h06,8'h04,8'h00},
    '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},
    '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF}};
  bit         red_en [5] = '{1, 0, 0, 1, 1};
  bit         grn_en [5] = '{0, 1, 1, 0, 1};
  bit         blinks [5] = '{0, 1, 1, 0, 1};
  logic [7:0] seg_tab[5] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};

  // Model state
  int m_mode     = 0;
  int scan_ticks = 0;  // powered clocks since reset
  int blink_n    = 0;  // powered clocks since last mode change / reset
  int anchor     = 0;  // blink_n at the last power-up (phase forced on there)

  function automatic int decode(input logic [3:0] s);
    if (s[2]) return 3;
    if (s[3]) return 4;
    if (s[0]) return 1;
    if (s[1]) return 2;
    return 0;
  endfunction

  task automatic step(input logic r_n, input logic s, input logic [3:0] st);
    out_t       e;
    int         d, ri;
    bit         ph, lit;
    logic [7:0] one;
    @(negedge clk);
    rst = r_n; sw = s; state_in = st;
    e = '{row:8'hFF, col_r:8'h00, col_g:8'h00, seg_row:8'hFF, seg_col:8'h00};
    if (!r_n) begin
      m_mode = 0; scan_ticks = 0; blink_n = 0; anchor = 0;
    end else begin
      d = decode(st);
      if (s) begin
        one = 8'h01;
        ri  = (scan_ticks / SCAN_DIV) % 8;
        // Phase is on for an even number of half-periods since the anchor.
        ph  = (((blink_n / BLINK_DIV) - (anchor / BLINK_DIV)) % 2) == 0;
        lit = !blinks[m_mode] || ph;
        e.row     = ~(one << ri);
        e.col_r   = (lit && red_en[m_mode]) ? pat_tab[m_mode][ri] : 8'h00;
        e.col_g   = (lit && grn_en[m_mode]) ? pat_tab[m_mode][ri] : 8'h00;
        e.seg_row = 8'hFE;
        e.seg_col = seg_tab[m_mode];
        scan_ticks++;
      end
      if (d != m_mode)  begin blink_n = 0; anchor = 0; end
      else if (!s)      anchor = blink_n;
      else              blink_n++;
      m_mode = d;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one output word per clock, sampled just after the edge.
  initial begin
    out_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{row:row, col_r:col_r, col_g:col_g, seg_row:seg_row, seg_col:seg_col};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got row=%h r=%h g=%h sr=%h sc=%h want row=%h r=%h g=%h sr=%h sc=%h",
                   cyc, a.row, a.col_r, a.col_g, a.seg_row, a.seg_col,
                   e.row, e.col_r, e.col_g, e.seg_row, e.seg_col);
        end
      end
    end
  end

  logic [3:0] onehot_tab [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    logic [3:0] st;
    int         len;
    // reset state
    repeat (2) step(1'b0, 1'b0, 4'h0);
    // idle frame scan
    repeat (40)  step(1'b1, 1'b1, 4'b0000);
    // left turn through a full blink period
    repeat (140) step(1'b1, 1'b1, 4'b0001);
    // brake wins over right
    repeat (80)  step(1'b1, 1'b1, 4'b0110);
    // hazard blinking
    repeat (140) step(1'b1, 1'b1, 4'b1000);
    // power off then on mid-hazard
    repeat (3)   step(1'b1, 1'b0, 4'b1000);
    repeat (20)  step(1'b1, 1'b1, 4'b1000);
    repeat (20)  step(1'b1, 1'b1, 4'b0010);
    // reset mid-operation with sw on
    step(1'b0, 1'b1, 4'b0001);
    repeat (10)  step(1'b1, 1'b1, 4'b0001);
    // randomized segments
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 9) < 6) st = onehot_tab[$urandom_range(0, 4)];
      else                          st = 4'($urandom);
      len = $urandom_range(1, 200);
      for (int k = 0; k < len; k++)
        step(($urandom_range(0, 299) != 0), ($urandom_range(0, 29) != 0), st);
    end
    // drain, bounded
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
